// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if -- data-memory request/response bundle.
//
// Carries one outstanding request from the MEM stage to the data memory and
// the memory's completion back.
//   dmem_req    master->slave  request valid, held until dmem_ack
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  DSIZE request address
//   dmem_wdata  master->slave  DSIZE write data
//   dmem_ack    slave->master  completion strobe
//   dmem_rdata  slave->master  DSIZE read data, valid while dmem_ack=1
//
// Widths come from the shared DSIZE/ISIZE/ASIZE defines; the guarded
// defaults below apply only when no project-wide define file set them first.
// -----------------------------------------------------------------------------
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif

interface mem_access_stage_if;
    logic               dmem_req;
    logic               dmem_we;
    logic [`DSIZE-1:0]  dmem_addr;
    logic [`DSIZE-1:0]  dmem_wdata;
    logic               dmem_ack;
    logic [`DSIZE-1:0]  dmem_rdata;

    // Pipeline stage side: issues requests.
    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    // Memory side: serves requests.
    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage -- MEM pipeline stage with a variable-latency data memory.
//
// Non-memory instructions pass straight through to the MEM/WB register in one
// cycle (ALU result, or the link PC for jal). Loads and stores take a fresh
// IDLE->ACCESS pass: operands are latched on entry, a request is held on the
// dmem bus until the memory acks, and the upstream pipeline is stalled until
// the completing edge. A writeback bubble is inserted on every cycle the
// stage does not complete an instruction.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous, active-low reset
//   aluResult_in        ALU result / memory address from EXE_MEM
//   wdata_in            store data from EXE_MEM
//   PC_in               link value for jal (zero-extended / truncated to DSIZE)
//   waddr_in, wen_in    destination register and its write enable
//   memWrite_in, memRead_in, memtoReg_in, jal_in   control bits
//   dmem                data-memory bus (master side)
//   stall_out           combinational; freezes PC..EXE_MEM while 1
//   wb_data_out, waddr_out_MEM_WB, wen_out_MEM_WB   registered writeback
//   mem_err             sticky access-timeout flag
//
// Configuration
//   MEM_ACCESS_TIMEOUT_EN  when defined, an access with no ack for 16 ACCESS
//                          cycles is abandoned: bubble, back to IDLE, mem_err
//                          set until reset. When undefined ACCESS waits
//                          forever and mem_err is tied low.
// -----------------------------------------------------------------------------
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif

module mem_access_stage (
    input  logic                clk,
    input  logic                rst,

    input  logic [`DSIZE-1:0]   aluResult_in,
    input  logic [`DSIZE-1:0]   wdata_in,
    input  logic [`ISIZE-1:0]   PC_in,
    input  logic [`ASIZE-1:0]   waddr_in,
    input  logic                wen_in,
    input  logic                memWrite_in,
    input  logic                memRead_in,
    input  logic                memtoReg_in,
    input  logic                jal_in,

    mem_access_stage_if.master  dmem,

    output logic                stall_out,
    output logic [`DSIZE-1:0]   wb_data_out,
    output logic [`ASIZE-1:0]   waddr_out_MEM_WB,
    output logic                wen_out_MEM_WB,
    output logic                mem_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,      state_d;

    // Operands captured on ACCESS entry; drive the bus while the request is
    // outstanding so upstream changes cannot disturb it.
    logic [`DSIZE-1:0]  addr_q,       addr_d;
    logic [`DSIZE-1:0]  wdata_q,      wdata_d;
    logic               we_q,         we_d;
    logic [`ASIZE-1:0]  waddr_lat_q,  waddr_lat_d;
    logic               wen_lat_q,    wen_lat_d;
    logic               memtoreg_q,   memtoreg_d;

    // MEM/WB register.
    logic [`DSIZE-1:0]  wb_data_q,    wb_data_d;
    logic [`ASIZE-1:0]  waddr_out_q,  waddr_out_d;
    logic               wen_out_q,    wen_out_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [3:0]         tmo_cnt_q,    tmo_cnt_d;
    logic               mem_err_q,    mem_err_d;
`endif

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic               memop;
    logic               in_access;
    logic               timeout_hit;
    logic [`DSIZE-1:0]  pc_ext;

    assign memop     = memRead_in | memWrite_in;
    assign in_access = (state_q == ST_ACCESS);

    // Link value resized to the datapath width.
    generate
        if (`ISIZE < `DSIZE) begin : g_pc_zext
            assign pc_ext = {{(`DSIZE-`ISIZE){1'b0}}, PC_in};
        end else begin : g_pc_trunc
            assign pc_ext = PC_in[`DSIZE-1:0];
        end
    endgenerate

`ifdef MEM_ACCESS_TIMEOUT_EN
    // The counter reads 0 in the first ACCESS cycle, so 15 marks the 16th
    // consecutive cycle without an ack.
    assign timeout_hit = in_access & ~dmem.dmem_ack & (tmo_cnt_q == 4'hF);
`else
    assign timeout_hit = 1'b0;
`endif

    // Stall is released on the completing (or abandoning) cycle so upstream
    // advances on the same edge. Gating with rst drops it immediately when
    // reset asserts, even if a memop is still presented.
    assign stall_out = rst & ((~in_access & memop) |
                              (in_access & ~dmem.dmem_ack & ~timeout_hit));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        waddr_lat_d = waddr_lat_q;
        wen_lat_d   = wen_lat_q;
        memtoreg_d  = memtoreg_q;
        wb_data_d   = wb_data_q;
        waddr_out_d = waddr_out_q;
        wen_out_d   = wen_out_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        mem_err_d   = mem_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // dmem_ack is deliberately not looked at here.
                if (memop) begin
                    state_d     = ST_ACCESS;
                    addr_d      = aluResult_in;
                    wdata_d     = wdata_in;
                    we_d        = memWrite_in;   // read+write counts as write
                    waddr_lat_d = waddr_in;
                    wen_lat_d   = wen_in;
                    memtoreg_d  = memtoReg_in;
                    wen_out_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    tmo_cnt_d   = 4'd0;
`endif
                end else begin
                    wb_data_d   = jal_in ? pc_ext : aluResult_in;
                    waddr_out_d = waddr_in;
                    wen_out_d   = wen_in;
                end
            end

            ST_ACCESS: begin
                if (dmem.dmem_ack) begin
                    state_d     = ST_IDLE;
                    wb_data_d   = memtoreg_q ? dmem.dmem_rdata : addr_q;
                    waddr_out_d = waddr_lat_q;
                    wen_out_d   = wen_lat_q;
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    wen_out_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    mem_err_d   = 1'b1;
`endif
                end else begin
                    wen_out_d   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    tmo_cnt_d   = tmo_cnt_q + 4'd1;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            waddr_lat_q <= '0;
            wen_lat_q   <= 1'b0;
            memtoreg_q  <= 1'b0;
            wb_data_q   <= '0;
            waddr_out_q <= '0;
            wen_out_q   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q   <= 4'd0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            waddr_lat_q <= waddr_lat_d;
            wen_lat_q   <= wen_lat_d;
            memtoreg_q  <= memtoreg_d;
            wb_data_q   <= wb_data_d;
            waddr_out_q <= waddr_out_d;
            wen_out_q   <= wen_out_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            mem_err_q   <= mem_err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The request follows the state register directly, so an asynchronous
    // reset during ACCESS withdraws it at once.
    assign dmem.dmem_req   = in_access;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign wb_data_out      = wb_data_q;
    assign waddr_out_MEM_WB = waddr_out_q;
    assign wen_out_MEM_WB   = wen_out_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule
